keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4-row × 3-column telephone-style matrix keypad, debounces it, and produces the `key[3:0]` code consumed by the alarm controller and key register. It sits between the keypad pins and the alarm clock top. It drives rows, samples columns, and presents a stable digit code (or NOKEY) plus a one-cycle press strobe.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven before its columns are sampled; must be ≥ 4.
- `DEBOUNCE_SAMPLES`, default 8: consecutive identical samples required to accept a press or a release; must be ≥ 2.
- `clock`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `col_n`, input, 3: column lines, active-low, externally pulled up, asynchronous to `clock`.
- `row_n`, output, 4: row drives, active-low, exactly one low at any time.
- `key`, output, 4: 0–9 = digit held; 4'hA (NOKEY) = no valid key.
- `key_pulse`, output, 1: high for one cycle when `key` changes from NOKEY to a digit.

## Operation
- `col_n` passes through a 2-flop synchronizer. All decisions use the synchronized `col_s`.
- A divider `div_cnt` counts 0..SCAN_DIV-1 and wraps. A sample tick occurs when `div_cnt == SCAN_DIV-1`.
- Key map, as row/column → code:
  - r0 = 1, 2, 3
  - r1 = 4, 5, 6
  - r2 = 7, 8, 9
  - r3 = `*`, 0, `#`
  - `*` and `#` are treated as no key: ignored in SCAN.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN**
  - On each tick, if exactly one column is low and it maps to a digit: capture row/column, keep the current row driven, set `match_cnt = 1`, go to DEBOUNCE.
  - Otherwise, advance to the next row (r3 wraps to r0).
  - Zero columns low, two or more columns low, or `*`/`#`: no capture.
- **DEBOUNCE**
  - On each tick, if the same single column is low, increment `match_cnt`. When it reaches DEBOUNCE_SAMPLES, load `key` with the digit, assert `key_pulse`, and go to PRESSED.
  - Any other pattern: return to SCAN, advance to the next row, `key` stays NOKEY.
- **PRESSED**
  - The row stays driven and `key` holds the digit.
  - On a tick with the captured column high (released) or a different pattern: `match_cnt = 1`, go to RELEASE.
- **RELEASE**
  - On each tick with no column low, increment `match_cnt`. At DEBOUNCE_SAMPLES: `key` = NOKEY, go to SCAN, advance the row.
  - If the captured column is low again on a tick, return to PRESSED with no new `key_pulse` (bounce on release).
  - A different column low counts as not released: `match_cnt` resets to 0 and the state stays RELEASE.
- A second key pressed while one is held is not reported. Only the first key is reported until it is fully released.

## Timing
- Reset values:
  - `row_n` = 4'b1110 (r0)
  - `key` = 4'hA
  - `key_pulse` = 0
  - state SCAN
  - `div_cnt` = 0
  - `match_cnt` = 0
- The `col_n` → `col_s` latency is 2 cycles. SCAN_DIV ≥ 4 guarantees the sample reflects the currently driven row.
- `row_n` changes on the cycle after the tick that advances it.
- Press latency, measured from the capturing tick: `key` and `key_pulse` update on the clock edge of the (DEBOUNCE_SAMPLES-1)-th following tick, i.e. (DEBOUNCE_SAMPLES-1)×SCAN_DIV cycles after capture.
- Release latency is the same, counted from the first released tick.
- `key` is registered and changes only on ticks. `key_pulse` is registered and lasts exactly 1 cycle.
- `div_cnt` free-runs and is never reset by state changes.
- If reset asserts mid-operation, everything returns to reset values immediately. A key still held after reset is re-detected from SCAN and produces a new `key_pulse`.

## Structure
- Shared package `keypad_pkg`:
  - NOKEY = 4'hA
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - function `key_code(row, col)` returning a 4-bit code, with 4'hF for `*` and `#`
- Sub-module `keypad_sync`: parameterized-width 2-flop synchronizer with async reset to all-ones (idle high).
- The FSM, divider, row register and match counter stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SAMPLES=3.

- **Reset:** assert `reset` mid-scan → `row_n` = 1110, `key` = A, `key_pulse` = 0 within the same cycle. Deassert → rows cycle 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- **Clean press of '5':** model pulls `col_n[1]` low while `row_n[1]` is low → `key` = 5 and one `key_pulse` 8 cycles after the capturing tick. `row_n` frozen at 1101. Release → `key` = A 8 cycles after the first released tick, and scanning resumes.
- **Bounce:** press '0', toggle the column on the 2nd sample → return to SCAN, no pulse, `key` = A. Hold steady afterwards → `key` = 0 with a single pulse.
- **Release bounce:** while '9' is held, release for 1 sample then press again → `key` stays 9 with no second pulse. Final release for 3 samples → A.
- **Ignored inputs:** press `*`, then `#`, then '1' and '2' together → `key` stays A and no pulse for 20 scan rounds.
- **Second key:** hold '7' and press '3' → `key` stays 7. Release '7' while '3' is held → `key` = A after debounce, then 3 with a new pulse on the next scan.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM states and the
// row/column to key-code map.
package keypad_pkg;

    localparam logic [3:0] NOKEY  = 4'hA;
    localparam logic [3:0] BADKEY = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    // Rows 0..2 hold digits 1..9; row 3 holds '*', '0', '#'. '*', '#' and
    // out-of-range columns map to BADKEY.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = BADKEY;
        if (col != 2'd3) begin
            if (row != 2'd3) begin
                code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
            end else if (col == 2'd1) begin
                code = 4'd0;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for active-low inputs; resets to all-ones (idle).
module keypad_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column sampling, debounce, and a
// registered digit code with a one-cycle press strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV         = 1000,
    parameter int unsigned DEBOUNCE_SAMPLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_pulse
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned MW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_SAMPLES);

    logic [2:0]    col_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    state_t        state, state_nxt;
    logic [1:0]    row, row_nxt;
    logic [1:0]    cap_col, cap_col_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [3:0]    key_nxt;
    logic          key_pulse_nxt;
    logic          one_low;
    logic [1:0]    col_idx;
    logic          cap_held;

    keypad_sync #(.WIDTH(3)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_n),
        .q     (col_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign row_n    = ~(4'b0001 << row);
    assign cap_held = (col_s == ~(3'b001 << cap_col));

    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (col_s)
            3'b110:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            3'b011:  col_idx = 2'd2;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row       <= 2'd0;
            cap_col   <= 2'd0;
            match_cnt <= '0;
            key       <= NOKEY;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            cap_col   <= cap_col_nxt;
            match_cnt <= match_nxt;
            key       <= key_nxt;
            key_pulse <= key_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        cap_col_nxt   = cap_col;
        match_nxt     = match_cnt;
        key_nxt       = key;
        key_pulse_nxt = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low && key_code(row, col_idx) != BADKEY) begin
                        cap_col_nxt = col_idx;
                        match_nxt   = MW'(1);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_nxt = row + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (cap_held) begin
                        match_nxt = match_cnt + MW'(1);
                        if (match_nxt == MATCH_DONE) begin
                            key_nxt       = key_code(row, cap_col);
                            key_pulse_nxt = 1'b1;
                            state_nxt     = PRESSED;
                        end
                    end else begin
                        state_nxt = SCAN;
                        row_nxt   = row + 2'd1;
                    end
                end
                PRESSED: begin
                    if (!cap_held) begin
                        match_nxt = MW'(1);
                        state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    // Captured column low again is a release bounce; any other
                    // low column restarts the release count without leaving.
                    if (col_s == 3'b111) begin
                        match_nxt = match_cnt + MW'(1);
                        if (match_nxt == MATCH_DONE) begin
                            key_nxt   = NOKEY;
                            state_nxt = SCAN;
                            row_nxt   = row + 2'd1;
                        end
                    end else if (!col_s[cap_col]) begin
                        state_nxt = PRESSED;
                    end else begin
                        match_nxt = '0;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=3 and a
// behavioural keypad matrix model driving col_n from row_n.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       key_pulse;

    logic [2:0] pressed [4];

    int n_checks   = 0;
    int n_fail     = 0;
    int k          = 0;
    int pulse_cnt  = 0;
    int pulse_base = 0;

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .key       (key),
        .key_pulse (key_pulse)
    );

    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~pressed[r];
        end
    end

    always @(posedge clock) begin
        #2;
        if (key_pulse === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int t);
        repeat (t - k) @(negedge clock);
        k = t;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        pulse_base = pulse_cnt;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    endtask

    function automatic logic [3:0] pulses();
        return 4'(pulse_cnt - pulse_base);
    endfunction

    initial begin
        release_all();

        // Reset mid-scan, then free scanning
        do_reset();
        go_to(6);
        chk("row_pre_reset", row_n, 4'b1101);
        reset = 1'b1;
        #1;
        chk("row_async_rst", row_n, 4'b1110);
        chk("key_async_rst", key, 4'hA);
        chk("pulse_async_rst", {3'b000, key_pulse}, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        pulse_base = pulse_cnt;
        go_to(3);  chk("scan_r0", row_n, 4'b1110);
        go_to(4);  chk("scan_r1", row_n, 4'b1101);
        go_to(8);  chk("scan_r2", row_n, 4'b1011);
        go_to(12); chk("scan_r3", row_n, 4'b0111);
        go_to(16); chk("scan_wrap", row_n, 4'b1110);

        // Clean press of '5': captured at tick 8, reported at tick 16
        do_reset();
        pressed[1] = 3'b010;
        go_to(15); chk("p5_key_early", key, 4'hA);
        chk("p5_pulse_early", {3'b000, key_pulse}, 4'd0);
        go_to(16); chk("p5_key", key, 4'd5);
        chk("p5_pulse", {3'b000, key_pulse}, 4'd1);
        go_to(17); chk("p5_pulse_end", {3'b000, key_pulse}, 4'd0);
        chk("p5_row_frozen", row_n, 4'b1101);
        release_all();
        go_to(27); chk("p5_rel_early", key, 4'd5);
        go_to(28); chk("p5_rel_key", key, 4'hA);
        chk("p5_rel_row", row_n, 4'b1011);
        go_to(32); chk("p5_resume", row_n, 4'b0111);
        chk("p5_pulses", pulses(), 4'd1);

        // Bounce on '0': captured at tick 16, lost at tick 20
        do_reset();
        pressed[3] = 3'b010;
        go_to(17);
        release_all();
        go_to(20); chk("b0_row", row_n, 4'b1110);
        chk("b0_key", key, 4'hA);
        chk("b0_nopulse", pulses(), 4'd0);
        pressed[3] = 3'b010;
        go_to(43); chk("b0_key_early", key, 4'hA);
        go_to(44); chk("b0_key", key, 4'd0);
        chk("b0_pulse", {3'b000, key_pulse}, 4'd1);
        go_to(45); chk("b0_pulses", pulses(), 4'd1);

        // Release bounce on '9'
        do_reset();
        pressed[2] = 3'b100;
        go_to(20); chk("r9_key", key, 4'd9);
        go_to(21);
        release_all();
        go_to(25);
        pressed[2] = 3'b100;
        go_to(28); chk("r9_bounce_key", key, 4'd9);
        go_to(33); chk("r9_pulses", pulses(), 4'd1);
        release_all();
        go_to(43); chk("r9_rel_early", key, 4'd9);
        go_to(44); chk("r9_rel_key", key, 4'hA);
        chk("r9_pulses_end", pulses(), 4'd1);

        // Ignored: '*', '#', then '1'+'2' together
        do_reset();
        pressed[3] = 3'b001;
        go_to(107); chk("ign_star", key, 4'hA);
        pressed[3] = 3'b100;
        go_to(214); chk("ign_hash", key, 4'hA);
        release_all();
        pressed[0] = 3'b011;
        go_to(320); chk("ign_double", key, 4'hA);
        chk("ign_pulses", pulses(), 4'd0);

        // Second key: hold '7', add '3', release '7'
        release_all();
        do_reset();
        pressed[2] = 3'b001;
        go_to(20); chk("k7_key", key, 4'd7);
        go_to(21);
        pressed[0] = 3'b100;
        go_to(40); chk("k7_hold_key", key, 4'd7);
        chk("k7_hold_row", row_n, 4'b1011);
        chk("k7_pulses", pulses(), 4'd1);
        pressed[2] = 3'b000;
        go_to(51); chk("k7_rel_early", key, 4'd7);
        go_to(52); chk("k7_rel_key", key, 4'hA);
        chk("k7_rel_row", row_n, 4'b0111);
        go_to(67); chk("k3_early", key, 4'hA);
        go_to(68); chk("k3_key", key, 4'd3);
        chk("k3_pulse", {3'b000, key_pulse}, 4'd1);
        go_to(69); chk("k3_pulses", pulses(), 4'd2);

        // Reset while '3' is held: cleared at once, then re-detected
        reset = 1'b1;
        #1;
        chk("hr_key", key, 4'hA);
        chk("hr_row", row_n, 4'b1110);
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        pulse_base = pulse_cnt;
        go_to(11); chk("hr_key_early", key, 4'hA);
        go_to(12); chk("hr_key_again", key, 4'd3);
        chk("hr_pulse", {3'b000, key_pulse}, 4'd1);
        go_to(13); chk("hr_pulses", pulses(), 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
